// File: rtl/stage_pkg.sv
// Shared constants for stage1_multi: FSM states, step indices, the leg angle
// list, and the fixed-point coefficient helpers that turn the geometry
// parameters into the OFFSET constant and the KC/KS tables.
package stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Steps 0..5 issue products; step 6 only drains the multiplier register.
  localparam logic [2:0] STEP_LAST  = 3'd5;
  localparam logic [2:0] STEP_DRAIN = 3'd6;

  localparam int NUM_BETA = 6;

  // Leg angle list in degrees: {90, 90, 330, 330, 210, 210}.
  function automatic int beta_deg(int i);
    int d;
    case (i % NUM_BETA)
      0, 1:    d = 90;
      2, 3:    d = 330;
      default: d = 210;
    endcase
    return d;
  endfunction

  // Integer square root, floor.
  function automatic longint isqrt(longint x);
    longint r;
    longint t;
    r = 0;
    for (int b = 30; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  // Square root rounded to nearest.
  function automatic longint round_sqrt(longint x);
    longint r;
    r = isqrt(x);
    if (x - r * r > r) r = r + 1;
    return r;
  endfunction

  function automatic int offset(int s_len, int a_rad);
    return s_len * s_len - a_rad * a_rad;
  endfunction

  // round(2a*cos(beta)*2^frac); cos(+-30deg) = sqrt(3)/2 so the magnitude is
  // sqrt(3 * a^2 * 4^frac), which keeps this exact without real arithmetic.
  function automatic int kc_coef(int id, int a_rad, int frac);
    longint rt3;
    int     k;
    rt3 = round_sqrt(longint'(3) * a_rad * a_rad * (longint'(1) << (2 * frac)));
    case (beta_deg(id))
      330:     k = int'(rt3);
      210:     k = -int'(rt3);
      default: k = 0;
    endcase
    return k;
  endfunction

  // round(2a*sin(beta)*2^frac); sin is +1 or -1/2 for the listed angles.
  function automatic int ks_coef(int id, int a_rad, int frac);
    int k;
    case (beta_deg(id))
      90:       k = 2 * a_rad * (1 << frac);
      330, 210: k = -(a_rad * (1 << frac));
      default:  k = 0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/stage1_multi_if.sv
// Input-vector / result handshake bundle for stage1_multi.
interface stage1_multi_if #(
  parameter int LW  = 9,
  parameter int IDW = 3
);
  logic                   in_valid;
  logic                   in_ready;
  logic [IDW-1:0]         leg_id;
  logic signed [LW-1:0]   lx;
  logic signed [LW-1:0]   ly;
  logic [LW-2:0]          lz;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [2*LW:0]   L;
  logic [LW+4:0]          M;
  logic signed [LW+6:0]   N;
  logic [IDW-1:0]         out_leg;
  logic                   err;

  modport slave (
    input  in_valid, leg_id, lx, ly, lz, out_ready,
    output in_ready, out_valid, L, M, N, out_leg, err
  );

  modport master (
    output in_valid, leg_id, lx, ly, lz, out_ready,
    input  in_ready, out_valid, L, M, N, out_leg, err
  );
endinterface

// File: rtl/stage1_multi_shared_mul.sv
// Registered signed multiplier with clock enable, one cycle of latency.
module shared_mul #(
  parameter int AW = 10,
  parameter int BW = 16
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    i_ce,
  input  logic signed [AW-1:0]    i_a,
  input  logic signed [BW-1:0]    i_b,
  output logic signed [AW+BW-1:0] o_p
);

  // Product register, updated only while a step is being issued.
  always_ff @(posedge clock or posedge rst) begin
    if (rst)       o_p <= '0;
    else if (i_ce) o_p <= (AW+BW)'(i_a) * (AW+BW)'(i_b);
  end

endmodule

// File: rtl/stage1_multi.sv
// First stage of the leg-length solver: from one leg vector it computes
// L = |l|^2 - OFFSET, M = 2a*lz and N = (KC*lx + KS*ly) >>> FRAC using a
// single shared multiplier stepped through six products.
module stage1_multi
  import stage_pkg::*;
#(
  parameter int LW       = 9,
  parameter int NUM_LEGS = 6,
  parameter int A_RAD    = 25,
  parameter int S_LEN    = 120,
  parameter int FRAC     = 8
) (
  input  logic          clock,
  input  logic          rst,
  stage1_multi_if.slave bus
);

  localparam int IDW    = (NUM_LEGS > 1) ? $clog2(NUM_LEGS) : 1;
  localparam int AW     = LW + 1;
  localparam int BW     = FRAC + 8;
  localparam int PW     = AW + BW;
  localparam int LAW    = 2 * LW + 2;
  localparam int NAW    = (PW > 2 * LW + 8) ? PW : 2 * LW + 8;
  localparam int MW     = LW + 5;
  localparam int LOW    = 2 * LW + 1;
  localparam int NOW    = LW + 7;
  localparam int OFFSET = offset(S_LEN, A_RAD);

  state_e                r_state;
  logic [2:0]            r_step;
  logic signed [LW-1:0]  r_lx, r_ly;
  logic [LW-2:0]         r_lz;
  logic [IDW-1:0]        r_id;
  logic signed [LAW-1:0] r_lacc;
  logic [MW-1:0]         r_macc;
  logic signed [NAW-1:0] r_nacc;
  logic signed [LOW-1:0] r_L;
  logic [MW-1:0]         r_M;
  logic signed [NOW-1:0] r_N;
  logic [IDW-1:0]        r_out_leg;
  logic                  r_err;
  logic                  r_out_valid;

  logic                  w_in_ready, w_accept, w_ce, w_id_bad;
  logic signed [AW-1:0]  w_a, w_lz_a;
  logic signed [BW-1:0]  w_b, w_lz_b, w_kc, w_ks;
  logic signed [PW-1:0]  w_p;
  logic signed [NAW-1:0] w_nsum;

  // Per-leg coefficients resolved at elaboration.
  logic signed [BW-1:0]  w_kc_tab [NUM_LEGS];
  logic signed [BW-1:0]  w_ks_tab [NUM_LEGS];

  for (genvar g = 0; g < NUM_LEGS; g++) begin : g_coef
    assign w_kc_tab[g] = BW'(kc_coef(g, A_RAD, FRAC));
    assign w_ks_tab[g] = BW'(ks_coef(g, A_RAD, FRAC));
  end

  // Coefficient lookup; an unknown leg id gets zero coefficients and flags err.
  always_comb begin
    w_kc     = '0;
    w_ks     = '0;
    w_id_bad = 1'b1;
    for (int i = 0; i < NUM_LEGS; i++) begin
      if (r_id == IDW'(i)) begin
        w_kc     = w_kc_tab[i];
        w_ks     = w_ks_tab[i];
        w_id_bad = 1'b0;
      end
    end
  end

  assign w_lz_a = AW'($signed({1'b0, r_lz}));
  assign w_lz_b = BW'($signed({1'b0, r_lz}));

  // Operand select for the shared multiplier, one product per step.
  always_comb begin
    w_a = '0;
    w_b = '0;
    case (r_step)
      3'd0:    begin w_a = AW'(r_lx); w_b = BW'(r_lx);      end
      3'd1:    begin w_a = AW'(r_ly); w_b = BW'(r_ly);      end
      3'd2:    begin w_a = w_lz_a;    w_b = w_lz_b;         end
      3'd3:    begin w_a = w_lz_a;    w_b = BW'(2 * A_RAD); end
      3'd4:    begin w_a = AW'(r_lx); w_b = w_kc;           end
      3'd5:    begin w_a = AW'(r_ly); w_b = w_ks;           end
      default: ;
    endcase
  end

  assign w_ce = (r_state == ST_MUL) && (r_step <= STEP_LAST);

  shared_mul #(.AW(AW), .BW(BW)) u_mul (
    .clock (clock),
    .rst   (rst),
    .i_ce  (w_ce),
    .i_a   (w_a),
    .i_b   (w_b),
    .o_p   (w_p)
  );

  // A held result may be replaced in the same cycle it is consumed.
  assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_nsum     = r_nacc + NAW'(w_p);

  // Control FSM: the product landing at step s belongs to step s-1.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_step      <= '0;
      r_lx        <= '0;
      r_ly        <= '0;
      r_lz        <= '0;
      r_id        <= '0;
      r_lacc      <= '0;
      r_macc      <= '0;
      r_nacc      <= '0;
      r_L         <= '0;
      r_M         <= '0;
      r_N         <= '0;
      r_out_leg   <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_lx        <= bus.lx;
      r_ly        <= bus.ly;
      r_lz        <= bus.lz;
      r_id        <= bus.leg_id;
      r_lacc      <= '0;
      r_macc      <= '0;
      r_nacc      <= '0;
      r_step      <= '0;
      r_out_valid <= 1'b0;
      r_state     <= ST_MUL;
    end else begin
      case (r_state)
        ST_MUL: begin
          case (r_step)
            3'd1, 3'd2, 3'd3: r_lacc <= r_lacc + LAW'(w_p);
            3'd4:             r_macc <= MW'(w_p);
            3'd5:             r_nacc <= w_nsum;
            default: ;
          endcase
          if (r_step == STEP_DRAIN) begin
            r_L         <= LOW'(r_lacc - LAW'(OFFSET));
            r_M         <= r_macc;
            r_N         <= NOW'(w_nsum >>> FRAC);
            r_out_leg   <= r_id;
            r_err       <= w_id_bad;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_step <= r_step + 3'd1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.L         = r_L;
  assign bus.M         = r_M;
  assign bus.N         = r_N;
  assign bus.out_leg   = r_out_leg;
  assign bus.err       = r_err;

endmodule

// File: doc/stage1_multi.md
STAGE1_MULTI -- requirements
Module: stage1_multi

Interface
REQ-001 SHALL have parameter LW, default 9: signed width of lx/ly; lz width is LW-1 unsigned.
REQ-002 SHALL have parameter NUM_LEGS, default 6: number of legs served; IDW = max(1, clog2(NUM_LEGS)).
REQ-003 SHALL have parameter A_RAD, default 25: platform radius a; M coefficient = 2*A_RAD.
REQ-004 SHALL have parameter S_LEN, default 120: rod length s; OFFSET = S_LEN^2 - A_RAD^2 (13775 at defaults).
REQ-005 SHALL have parameter FRAC, default 8: fractional bits of the N coefficient table.
REQ-006 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have port in_valid, input, 1: input vector offered.
REQ-009 SHALL have port in_ready, output, 1: block accepts the vector this cycle.
REQ-010 SHALL have port leg_id, input, IDW: leg index selecting beta.
REQ-011 SHALL have ports lx and ly, input, LW signed: leg vector x and y.
REQ-012 SHALL have port lz, input, LW-1 unsigned: leg vector z.
REQ-013 SHALL have port out_valid, output, 1: result held and valid.
REQ-014 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-015 SHALL have port L, output, 2*LW+1 signed: lx^2+ly^2+lz^2-OFFSET.
REQ-016 SHALL have port M, output, LW+5 unsigned: 2*A_RAD*lz.
REQ-017 SHALL have port N, output, LW+7 signed: (KC[id]*lx + KS[id]*ly) >>> FRAC.
REQ-018 SHALL have ports out_leg (output, IDW: leg_id of the result) and err (output, 1: leg_id >= NUM_LEGS).

Function
REQ-019 SHALL implement FSM IDLE -> MUL -> DONE -> IDLE.
REQ-020 SHALL assert in_ready in IDLE, and in DONE only when out_ready=1 in that same cycle.
REQ-021 SHALL, on in_valid&&in_ready, capture lx, ly, lz and leg_id into working registers, clear the accumulators, and enter MUL; later input changes SHALL be ignored.
REQ-022 SHALL, in MUL, run one shared signed multiplier for six steps, step counter 0..5: lx*lx, ly*ly, lz*lz, (2*A_RAD)*lz, KC*lx, KS*ly.
REQ-023 SHALL accumulate steps 0-2 into the L accumulator, step 3 into M, and steps 4-5 into the N accumulator of at least 2*LW+8 bits.
REQ-024 SHALL enter DONE after step 5, registering L = Lacc-OFFSET, M, and N = Nacc arithmetically shifted right by FRAC (floor, no rounding); out_valid SHALL then be 1.
REQ-025 SHALL give a latency of exactly 7 cycles from the accept edge to the first out_valid=1 cycle.
REQ-026 SHALL hold L, M, N, out_leg and err stable while out_valid=1 and out_ready=0.
REQ-027 SHALL, on out_valid&&out_ready: go to IDLE with out_valid=0 if in_valid=0, else accept the new vector in that same cycle and go to MUL (back-to-back, 8-cycle issue interval).
REQ-028 SHALL use KC[i] = round(2*A_RAD*cos(beta_i)*2^FRAC) and KS[i] likewise with sin, for beta = {90, 90, 330, 330, 210, 210} deg; at defaults KC = {0, 0, 11085, 11085, -11085, -11085} and KS = {12800, 12800, -6400, -6400, -6400, -6400}.
REQ-029 SHALL, for leg_id >= NUM_LEGS, use KC = KS = 0 (so N = 0), compute L and M normally, and set err=1 with that result.
REQ-030 SHALL ensure no intermediate overflows for any legal input; L, M and N widths SHALL be exact for the full input range.

Reset
REQ-031 SHALL, on rst, asynchronously force the FSM to IDLE, step counter 0, out_valid 0, L/M/N/out_leg/err 0, and working and accumulator registers 0.
REQ-032 SHALL abandon any in-flight computation on rst asserted mid-MUL or in DONE, producing no out_valid after reset release until a new accept.
REQ-033 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Structure
REQ-034 SHALL place OFFSET, the KC/KS tables and the beta list in shared package stage_pkg, computed from the parameters.
REQ-035 SHALL instantiate one sub-module, shared_mul: a registered signed multiplier of LW+1 by FRAC+8 bits with CE, 1-cycle latency, and a pipeline accounted for in the step counter.

Verification
REQ-036 SHALL verify: leg 0, lx=10, ly=20, lz=100 -> L=-3275, M=5000, N=1000, out_valid on accept+7.
REQ-037 SHALL verify: leg 2, lx=100, ly=0, lz=0 -> L=-3775, M=0, N=4330.
REQ-038 SHALL verify: leg 4, lx=100, ly=40, lz=0 -> N=-5331, confirming floor shift.
REQ-039 SHALL verify: leg 0, lx=-256, ly=-256, lz=255 -> L=182322, M=12750, N=-12800.
REQ-040 SHALL verify: out_ready held 0 for 5 cycles, then pulsed with in_valid=1 -> outputs stable throughout, new vector accepted in the handshake cycle, next out_valid 7 cycles later.
REQ-041 SHALL verify: rst pulsed at MUL step 3, and leg_id=7 -> no stale out_valid after reset; leg 7 yields err=1, N=0, and correct L and M.
